// File: rtl/sobel_pkg.sv
// Shared types and helpers for the streaming Sobel edge filter.
// Gradient width is DATA_W + GRAD_GUARD. Each kernel arm sums to 4*max. The L1 sum of two arms fits with room to spare.
package sobel_pkg;

    typedef enum logic [1:0] {
        SOBEL_L1  = 2'd0,
        SOBEL_GX  = 2'd1,
        SOBEL_GY  = 2'd2,
        SOBEL_BIN = 2'd3
    } sobel_mode_t;

    // Gradients need DATA_W + GRAD_GUARD bits.
    localparam int GRAD_GUARD = 4;

    localparam int SAT_MAX_W = 32;

    function automatic logic [SAT_MAX_W-1:0] saturate(
        input logic [SAT_MAX_W-1:0] value,
        input int                   data_w
    );
        logic [SAT_MAX_W-1:0] limit;
        limit = (SAT_MAX_W'(1) << data_w) - SAT_MAX_W'(1);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One-line delay element for the Sobel window.
// The read is combinational and sees the old contents. The write lands on the clock edge, so reading and writing the same address in one cycle returns the old word.
module sobel_line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 128,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel filter with ready/valid on both sides and frame/row markers.
// Each accepted beat at (r,c) emits the gradient centred on (r-1,c-1) one cycle later.
module sobel_stream
    import sobel_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] threshold,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof
);

    localparam int GRAD_W = DATA_W + GRAD_GUARD;
    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);

    logic [CW-1:0]           col, eff_col, next_col;
    logic [RW-1:0]           row, eff_row, next_row;
    sobel_mode_t             mode_q;
    logic [DATA_W-1:0]       thr_q;
    logic                    accept, emit;
    logic [DATA_W-1:0]       a_rd, b_rd;
    logic [2:0][DATA_W-1:0]  cur, prev1, prev2;
    logic [GRAD_W-1:0]       sum_l, sum_r, sum_t, sum_b;
    logic signed [GRAD_W-1:0] gx, gy;
    logic [GRAD_W-1:0]       abs_gx, abs_gy, l1;
    logic [DATA_W-1:0]       result;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // A start-of-frame beat is always treated as pixel (0,0), whatever the counters say.
    always_comb begin
        eff_col  = in_sof ? '0 : col;
        eff_row  = in_sof ? '0 : row;
        next_col = eff_col + CW'(1);
        next_row = eff_row;
        if (eff_col == CW'(IMG_W - 1)) begin
            next_col = '0;
            next_row = (eff_row == RW'(IMG_H - 1)) ? '0 : eff_row + RW'(1);
        end
        emit = (eff_row >= RW'(2)) && (eff_col >= CW'(2));
    end

    sobel_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W), .AW(CW)) u_line_a (
        .clk     (clk),
        .en      (accept),
        .addr    (eff_col),
        .wr_data (in_data),
        .rd_data (a_rd)
    );

    sobel_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W), .AW(CW)) u_line_b (
        .clk     (clk),
        .en      (accept),
        .addr    (eff_col),
        .wr_data (a_rd),
        .rd_data (b_rd)
    );

    // Index 0 is the top row and 2 is the bottom row. The incoming column forms the right edge of the window.
    assign cur = {in_data, a_rd, b_rd};

    always_comb begin
        sum_r  = GRAD_W'(cur[0]) + (GRAD_W'(cur[1]) << 1) + GRAD_W'(cur[2]);
        sum_l  = GRAD_W'(prev2[0]) + (GRAD_W'(prev2[1]) << 1) + GRAD_W'(prev2[2]);
        sum_b  = GRAD_W'(prev2[2]) + (GRAD_W'(prev1[2]) << 1) + GRAD_W'(cur[2]);
        sum_t  = GRAD_W'(prev2[0]) + (GRAD_W'(prev1[0]) << 1) + GRAD_W'(cur[0]);
        gx     = $signed(sum_r - sum_l);
        gy     = $signed(sum_b - sum_t);
        abs_gx = (gx < 0) ? GRAD_W'(-gx) : GRAD_W'(gx);
        abs_gy = (gy < 0) ? GRAD_W'(-gy) : GRAD_W'(gy);
        l1     = abs_gx + abs_gy;
        case (mode_q)
            SOBEL_GX:  result = DATA_W'(saturate(SAT_MAX_W'(abs_gx), DATA_W));
            SOBEL_GY:  result = DATA_W'(saturate(SAT_MAX_W'(abs_gy), DATA_W));
            SOBEL_BIN: result = (l1 >= GRAD_W'(thr_q)) ? {DATA_W{1'b1}} : '0;
            default:   result = DATA_W'(saturate(SAT_MAX_W'(l1), DATA_W));
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col    <= '0;
            row    <= '0;
            prev1  <= '0;
            prev2  <= '0;
            mode_q <= SOBEL_L1;
            thr_q  <= '0;
        end else if (accept) begin
            col   <= next_col;
            row   <= next_row;
            prev2 <= prev1;
            prev1 <= cur;
            if (in_sof) begin
                mode_q <= sobel_mode_t'(mode);
                thr_q  <= threshold;
            end
        end
    end

    // The output register only reloads when its current beat is gone. Border beats leave it empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (in_ready) begin
            out_valid <= accept && emit;
            if (accept && emit) begin
                out_data <= result;
                out_sof  <= (eff_row == RW'(2)) && (eff_col == CW'(2));
                out_eol  <= (eff_col == CW'(IMG_W - 1));
                out_eof  <= (eff_row == RW'(IMG_H - 1)) && (eff_col == CW'(IMG_W - 1));
            end
        end
    end

endmodule

// File: tb/tb_sobel_stream.sv
// Self-checking bench for sobel_stream on an 8x6 frame.
// The reference computes each expected gradient directly from a whole-frame image array.
module tb_sobel_stream;

    localparam int DATA_W = 8;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 6;
    localparam int MAXV   = (1 << DATA_W) - 1;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_sof;
    logic [1:0]        mode;
    logic [DATA_W-1:0] threshold;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_sof;
    logic              out_eol;
    logic              out_eof;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sof;
        logic              eol;
        logic              eof;
    } exp_t;

    exp_t expq[$];
    int   img [IMG_H][IMG_W];
    int   checks = 0;
    int   errors = 0;
    int   ready_ctl = 0;
    int   frame_mode = 0;
    int   frame_thr = 0;
    int   out_count = 0;
    int   sof_count = 0;
    int   eol_count = 0;
    int   eof_count = 0;

    sobel_stream #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .mode      (mode),
        .threshold (threshold),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .out_eof   (out_eof)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Reference output for the pixel centred at (r,c), worked out from the whole image.
    function automatic int model_pixel(input int r, input int c, input int md, input int thr);
        int gx, gy, l1, v;
        gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
           - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
        gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
           - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        l1 = gx + gy;
        case (md)
            1:       v = gx;
            2:       v = gy;
            3:       return (l1 >= thr) ? MAXV : 0;
            default: v = l1;
        endcase
        return (v > MAXV) ? MAXV : v;
    endfunction

    function automatic void fill_flat(input int v);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                img[r][c] = v;
    endfunction

    function automatic void fill_step();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                img[r][c] = (c >= 4) ? 200 : 0;
    endfunction

    function automatic void fill_ramp();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                img[r][c] = 10 * r;
    endfunction

    function automatic void fill_random();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                img[r][c] = int'($urandom_range(0, MAXV));
    endfunction

    // Offers one pixel until the DUT accepts it, then queues the output that beat must produce.
    task automatic applyStimulus(input int r, input int c, input bit sof, input int md_in, input int thr_in);
        int   waited;
        exp_t e;
        waited    = 0;
        in_valid  = 1'b1;
        in_data   = DATA_W'(img[r][c]);
        in_sof    = sof;
        mode      = 2'(md_in);
        threshold = DATA_W'(thr_in);
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 500) begin
                checkOutput("in_ready_timeout", 0, 1);
                break;
            end
        end
        if (sof) begin
            frame_mode = md_in;
            frame_thr  = thr_in;
        end
        if (r >= 2 && c >= 2) begin
            e.data = DATA_W'(model_pixel(r - 1, c - 1, frame_mode, frame_thr));
            e.sof  = (r == 2 && c == 2);
            e.eol  = (c == IMG_W - 1);
            e.eof  = (r == IMG_H - 1 && c == IMG_W - 1);
            expq.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int md, input int thr, input int n_beats,
                              input int alt_md, input int alt_thr, input int alt_at);
        for (int i = 0; i < n_beats; i++) begin
            if (i >= alt_at)
                applyStimulus(i / IMG_W, i % IMG_W, i == 0, alt_md, alt_thr);
            else
                applyStimulus(i / IMG_W, i % IMG_W, i == 0, md, thr);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_empty", expq.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_counts();
        out_count = 0;
        sof_count = 0;
        eol_count = 0;
        eof_count = 0;
    endtask

    task automatic check_frame_counts(input string tag, input int n_out, input int n_sof,
                                      input int n_eol, input int n_eof);
        checkOutput({tag, "_out_count"}, out_count, n_out);
        checkOutput({tag, "_sof_count"}, sof_count, n_sof);
        checkOutput({tag, "_eol_count"}, eol_count, n_eol);
        checkOutput({tag, "_eof_count"}, eof_count, n_eof);
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_ctl)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 9) < 3);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Checks every transfer against the queued reference, and checks stalled outputs for stability.
    initial begin
        logic              held;
        logic [DATA_W-1:0] hd;
        logic [2:0]        hf;
        exp_t              e;
        held = 1'b0;
        hd   = '0;
        hf   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else begin
                checkOutput("in_ready_rule", int'(in_ready), int'(!out_valid || out_ready));
                if (held) begin
                    checkOutput("hold_valid", int'(out_valid), 1);
                    checkOutput("hold_data", int'(out_data), int'(hd));
                    checkOutput("hold_flags", int'({out_sof, out_eol, out_eof}), int'(hf));
                end
                held = out_valid && !out_ready;
                hd   = out_data;
                hf   = {out_sof, out_eol, out_eof};
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        checkOutput("unexpected_output", int'(out_data), -1);
                    end else begin
                        e = expq.pop_front();
                        checkOutput("out_data", int'(out_data), int'(e.data));
                        checkOutput("out_sof", int'(out_sof), int'(e.sof));
                        checkOutput("out_eol", int'(out_eol), int'(e.eol));
                        checkOutput("out_eof", int'(out_eof), int'(e.eof));
                        out_count++;
                        sof_count += int'(out_sof);
                        eol_count += int'(out_eol);
                        eof_count += int'(out_eof);
                    end
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sof    = 1'b0;
        mode      = 2'd0;
        threshold = '0;
        #3;
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_out_data", int'(out_data), 0);
        checkOutput("reset_flags", int'({out_sof, out_eol, out_eof}), 0);
        checkOutput("reset_in_ready", int'(in_ready), 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        fill_step();
        checkOutput("pin_step_gx_c3", model_pixel(2, 3, 1, 0), 255);
        checkOutput("pin_step_gx_c4", model_pixel(2, 4, 1, 0), 255);
        checkOutput("pin_step_gx_c2", model_pixel(2, 2, 1, 0), 0);
        checkOutput("pin_step_gx_c5", model_pixel(2, 5, 1, 0), 0);
        checkOutput("pin_step_gy", model_pixel(2, 3, 2, 0), 0);
        checkOutput("pin_step_bin_hi", model_pixel(3, 4, 3, 255), 255);
        checkOutput("pin_step_bin_lo", model_pixel(3, 1, 3, 255), 0);
        fill_ramp();
        checkOutput("pin_ramp_gy", model_pixel(2, 3, 2, 0), 80);
        checkOutput("pin_ramp_gx", model_pixel(3, 3, 1, 0), 0);
        fill_flat(100);
        checkOutput("pin_flat_l1", model_pixel(2, 2, 0, 0), 0);

        $display("[TB] flat frame, mode 0");
        ready_ctl = 0;
        clear_counts();
        send_frame(0, 0, IMG_W * IMG_H, 0, 0, IMG_W * IMG_H);
        drain();
        check_frame_counts("flat", 24, 1, 4, 1);

        $display("[TB] step frame, modes 1 and 2");
        fill_step();
        send_frame(1, 0, IMG_W * IMG_H, 1, 0, IMG_W * IMG_H);
        send_frame(2, 0, IMG_W * IMG_H, 2, 0, IMG_W * IMG_H);
        drain();

        $display("[TB] ramp frame, modes 2 and 1");
        fill_ramp();
        send_frame(2, 0, IMG_W * IMG_H, 2, 0, IMG_W * IMG_H);
        send_frame(1, 0, IMG_W * IMG_H, 1, 0, IMG_W * IMG_H);
        drain();

        $display("[TB] step frame, mode 3, mode/threshold changed mid-frame");
        fill_step();
        send_frame(3, 255, IMG_W * IMG_H, 2, 0, 20);
        drain();

        $display("[TB] random frames with 30 percent out_ready");
        ready_ctl = 1;
        clear_counts();
        fill_random();
        send_frame(0, 0, IMG_W * IMG_H, 0, 0, IMG_W * IMG_H);
        drain();
        check_frame_counts("rand_l1", 24, 1, 4, 1);
        clear_counts();
        fill_random();
        send_frame(3, 100, IMG_W * IMG_H, 3, 100, IMG_W * IMG_H);
        drain();
        check_frame_counts("rand_bin", 24, 1, 4, 1);

        $display("[TB] mid-frame in_sof resync");
        clear_counts();
        fill_random();
        send_frame(0, 0, 3 * IMG_W + 5, 0, 0, IMG_W * IMG_H);
        fill_step();
        send_frame(1, 0, IMG_W * IMG_H, 1, 0, IMG_W * IMG_H);
        drain();
        check_frame_counts("resync", 33, 2, 5, 1);

        $display("[TB] reset mid-row");
        ready_ctl = 0;
        clear_counts();
        fill_random();
        send_frame(0, 0, 2 * IMG_W + 3, 0, 0, IMG_W * IMG_H);
        checkOutput("pre_reset_out_valid", int'(out_valid), 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_reset_out_valid", int'(out_valid), 0);
        checkOutput("mid_reset_out_data", int'(out_data), 0);
        checkOutput("mid_reset_flags", int'({out_sof, out_eol, out_eof}), 0);
        checkOutput("mid_reset_in_ready", int'(in_ready), 1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        expq.delete();
        ready_ctl = 1;
        clear_counts();
        fill_random();
        send_frame(0, 0, IMG_W * IMG_H, 0, 0, IMG_W * IMG_H);
        drain();
        check_frame_counts("post_reset", 24, 1, 4, 1);

        ready_ctl = 0;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
